// File: rtl/button_event_decoder.sv
// Classifies a debounced, clk-synchronous button level into short, long and double press pulses.
// Optional auto-repeat while a long press is held is enabled by defining BTN_AUTOREPEAT_EN.
module button_event_decoder #(
  parameter int LONG_CYCLES       = 50_000_000,
  parameter int DOUBLE_GAP_CYCLES = 12_500_000,
  parameter int REPEAT_CYCLES     = 5_000_000,
  parameter int CNT_W = $clog2(
    ((LONG_CYCLES > DOUBLE_GAP_CYCLES) ? LONG_CYCLES : DOUBLE_GAP_CYCLES) > REPEAT_CYCLES ?
    ((LONG_CYCLES > DOUBLE_GAP_CYCLES) ? LONG_CYCLES : DOUBLE_GAP_CYCLES) : REPEAT_CYCLES) + 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_level,
  output logic       short_press,
  output logic       long_press,
  output logic       double_press,
  output logic       repeat_press,
  output logic [7:0] event_count
);

  typedef enum logic [2:0] {
    IDLE,
    HELD1,
    LONG,
    GAP,
    WAIT_REL
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             btn_prev;
  logic             rise;
  logic             fall;

  assign rise = btn_level & ~btn_prev;
  assign fall = ~btn_level & btn_prev;

  // One shared counter times the hold in HELD1, the release gap in GAP and, optionally, repeats in LONG.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      btn_prev     <= 1'b0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      event_count  <= '0;
`ifdef BTN_AUTOREPEAT_EN
      repeat_press <= 1'b0;
`endif
    end else begin
      btn_prev     <= btn_level;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      repeat_press <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rise) begin
            state <= HELD1;
            cnt   <= '0;
          end
        end
        // A release on the very cycle the hold would mature still counts as a release.
        HELD1: begin
          if (fall) begin
            state <= GAP;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            long_press  <= 1'b1;
            event_count <= event_count + 8'd1;
            state       <= LONG;
            cnt         <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        LONG: begin
          if (fall) begin
            state <= IDLE;
`ifdef BTN_AUTOREPEAT_EN
          end else if (btn_level) begin
            if (cnt == REPEAT_LAST) begin
              repeat_press <= 1'b1;
              cnt          <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
`endif
          end
        end
        // A second press arriving on the timeout cycle still forms a double.
        GAP: begin
          if (rise) begin
            double_press <= 1'b1;
            event_count  <= event_count + 8'd1;
            state        <= WAIT_REL;
          end else if (cnt == GAP_LAST) begin
            short_press <= 1'b1;
            event_count <= event_count + 8'd1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_REL: begin
          if (fall) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef BTN_AUTOREPEAT_EN
  assign repeat_press = 1'b0;
`endif

endmodule
